// File: rtl/proc_sequencer.sv
// Program sequencer: fetches instruction words from a synchronous-read memory
// and hands them one at a time to the simple processor, waiting for Done.
module proc_sequencer #(
    parameter int ADDR_W  = 5,
    parameter int TIMEOUT = 8
) (
    input  logic              Clock,
    input  logic              Resetn,
    input  logic              Start,
    input  logic              Stop,
    input  logic [ADDR_W-1:0] Length,
    output logic [ADDR_W-1:0] MemAddr,
    input  logic [15:0]       MemData,
    output logic [15:0]       DIN,
    output logic              Run,
    input  logic              Done,
    output logic              Busy,
    output logic              Halted,
    output logic              Error,
    output logic [ADDR_W-1:0] PC,
    output logic [15:0]       InstrCount
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, FETCH, ISSUE, WAIT} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] len_q, len_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [15:0]       count_q, count_d;
    logic              halted_q, halted_d;
    logic              error_q, error_d;
    logic              stop_q, stop_d;

    // NOTE: non-blocking assignments keep every register sampling pre-edge values.
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            state_q  <= IDLE;
            pc_q     <= '0;
            len_q    <= '0;
            cnt_q    <= '0;
            count_q  <= '0;
            halted_q <= 1'b0;
            error_q  <= 1'b0;
            stop_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            len_q    <= len_d;
            cnt_q    <= cnt_d;
            count_q  <= count_d;
            halted_q <= halted_d;
            error_q  <= error_d;
            stop_q   <= stop_d;
        end
    end

    always_comb begin
        // NOTE: hold-current defaults on every path prevent inferred latches.
        state_d  = state_q;
        pc_d     = pc_q;
        len_d    = len_q;
        cnt_d    = cnt_q;
        count_d  = count_q;
        halted_d = halted_q;
        error_d  = error_q;
        stop_d   = stop_q;

        if (Stop && state_q != IDLE)
            stop_d = 1'b1;

        case (state_q)
            IDLE: begin
                if (Start) begin
                    error_d = 1'b0;
                    count_d = '0;
                    if (Length != '0) begin
                        len_d    = Length;
                        pc_d     = '0;
                        halted_d = 1'b0;
                        stop_d   = 1'b0;
                        state_d  = FETCH;
                    end else begin
                        halted_d = 1'b1;
                    end
                end
            end
            FETCH: state_d = ISSUE;
            ISSUE: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (Done) begin
                    if (count_q != 16'hFFFF)
                        count_d = count_q + 16'd1;
                    // Completion wins over a pending stop on the last word.
                    if (pc_q == len_q - ADDR_W'(1)) begin
                        halted_d = 1'b1;
                        state_d  = IDLE;
                    end else if (stop_q || Stop) begin
                        stop_d  = 1'b0;
                        state_d = IDLE;
                    end else begin
                        pc_d    = pc_q + ADDR_W'(1);
                        state_d = FETCH;
                    end
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    error_d = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // The PC register doubles as the memory address, so MemAddr is registered.
    assign MemAddr    = pc_q;
    assign PC         = pc_q;
    assign DIN        = MemData;
    assign Run        = (state_q == ISSUE);
    assign Busy       = (state_q != IDLE);
    assign Halted     = halted_q;
    assign Error      = error_q;
    assign InstrCount = count_q;

endmodule

// File: tb/tb_proc_sequencer.sv
// Bench for proc_sequencer: instruction memory, a small processor model and a
// phase-counting reference model compared against the DUT every cycle.
module tb_proc_sequencer;

    localparam int ADDR_W  = 5;
    localparam int TIMEOUT = 8;

    logic              Clock = 1'b0;
    logic              Resetn = 1'b0;
    logic              Start = 1'b0;
    logic              Stop = 1'b0;
    logic [ADDR_W-1:0] Length = '0;
    logic [ADDR_W-1:0] MemAddr;
    logic [15:0]       MemData;
    logic [15:0]       DIN;
    logic              Run;
    logic              Done;
    logic              Busy;
    logic              Halted;
    logic              Error;
    logic [ADDR_W-1:0] PC;
    logic [15:0]       InstrCount;

    proc_sequencer #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .Clock(Clock), .Resetn(Resetn), .Start(Start), .Stop(Stop),
        .Length(Length), .MemAddr(MemAddr), .MemData(MemData), .DIN(DIN),
        .Run(Run), .Done(Done), .Busy(Busy), .Halted(Halted), .Error(Error),
        .PC(PC), .InstrCount(InstrCount)
    );

    always #5 Clock = ~Clock;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    always @(posedge Clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Synchronous-read instruction memory
    logic [15:0] prog [32];
    always @(posedge Clock) MemData <= prog[MemAddr];

    // Processor: mv/mvt finish in T1, add in T3; hang suppresses Done
    logic [15:0] r [8];
    logic [15:0] ir = '0;
    int          step = 0;
    logic        hang = 1'b0;

    assign Done = !hang && ((step == 1 && ir[15:14] == 2'b00) ||
                            (step == 3 && ir[15:13] == 3'b010));

    always @(posedge Clock) begin
        if (!Resetn) begin
            step <= 0;
            for (int i = 0; i < 8; i++) r[i] <= '0;
        end else if (Run) begin
            ir   <= DIN;
            step <= 1;
        end else if (step != 0) begin
            if (Done) begin
                step <= 0;
                case (ir[15:13])
                    3'd0: r[ir[11:9]] <= ir[12] ? {7'b0, ir[8:0]} : r[ir[2:0]];
                    3'd1: r[ir[11:9]] <= {ir[7:0], 8'h00};
                    3'd2: r[ir[11:9]] <= r[ir[11:9]] + (ir[12] ? {7'b0, ir[8:0]} : r[ir[2:0]]);
                    default: ;
                endcase
            end else if (step < 15) begin
                step <= step + 1;
            end
        end
    end

    // Reference model: m_t is the cycle index inside the current instruction
    // (0 fetch, 1 issue, >=2 waiting for Done).
    bit m_valid = 0, m_act = 0, m_halt = 0, m_err = 0, m_stop = 0;
    int m_t = 0, m_pc = 0, m_len = 0, m_cnt = 0;
    int run_log[$];
    int start_cyc = 0;

    always @(negedge Clock) begin
        bit eff_stop;
        if (m_valid) begin
            check("busy", Busy, m_act);
            check("run", Run, m_act && m_t == 1);
            check("pc", PC, m_pc);
            check("mem_addr", MemAddr, m_pc);
            check("halted", Halted, m_halt);
            check("error", Error, m_err);
            check("instr_count", InstrCount, m_cnt);
            if (m_act && m_t == 1) check("din", DIN, prog[m_pc]);
        end
        if (Run === 1'b1) run_log.push_back(cyc - start_cyc);

        if (Resetn !== 1'b1) begin
            m_valid = 1; m_act = 0; m_halt = 0; m_err = 0; m_stop = 0;
            m_t = 0; m_pc = 0; m_len = 0; m_cnt = 0;
        end else if (!m_act) begin
            if (Start) begin
                m_err = 0;
                m_cnt = 0;
                if (Length != 0) begin
                    m_act = 1; m_t = 0; m_pc = 0; m_len = int'(Length);
                    m_halt = 0; m_stop = 0;
                end else begin
                    m_halt = 1;
                end
            end
        end else begin
            eff_stop = m_stop || Stop;
            if (Stop) m_stop = 1;
            if (m_t >= 2) begin
                if (Done) begin
                    m_cnt = (m_cnt == 65535) ? 65535 : m_cnt + 1;
                    if (m_pc == m_len - 1) begin
                        m_halt = 1; m_act = 0;
                    end else if (eff_stop) begin
                        m_stop = 0; m_act = 0;
                    end else begin
                        m_pc++; m_t = 0;
                    end
                end else if (m_t - 1 == TIMEOUT) begin
                    m_err = 1; m_act = 0;
                end else begin
                    m_t++;
                end
            end else begin
                m_t++;
            end
        end
    end

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic start_pulse(input int len);
        Length = ADDR_W'(len);
        run_log.delete();
        start_cyc = cyc;
        Start = 1'b1;
        tick();
        Start = 1'b0;
    endtask

    task automatic wait_idle(input int budget, output int elapsed);
        elapsed = 0;
        while (Busy && elapsed < budget) begin
            tick();
            elapsed++;
        end
        check("idle_within_budget", Busy, 1'b0);
    endtask

    task automatic load_basic();
        prog[0] = 16'h1005;   // mv  r0,#5
        prog[1] = 16'h3201;   // mvt r1,#1
        prog[2] = 16'h4001;   // add r0,r1
    endtask

    function automatic int log_at(input int i);
        return (i < run_log.size()) ? run_log[i] : -1;
    endfunction

    initial begin
        int el;
        for (int i = 0; i < 32; i++) prog[i] = '0;
        repeat (2) tick();
        Resetn = 1'b1;
        tick();
        check("reset_busy", Busy, 1'b0);
        check("reset_pc", PC, 0);
        check("reset_count", InstrCount, 0);
        check("reset_halted", Halted, 1'b0);

        // Basic three-instruction program
        load_basic();
        start_pulse(3);
        wait_idle(40, el);
        check("run_count_basic", run_log.size(), 3);
        check("run_cycle0", log_at(0), 2);
        check("run_cycle1", log_at(1), 5);
        check("run_cycle2", log_at(2), 8);
        check("halted_basic", Halted, 1'b1);
        check("count_basic", InstrCount, 3);
        check("r0_basic", r[0], 16'h0105);
        check("r1_basic", r[1], 16'h0100);

        // Done timeout; Start also clears the Halted left by the last run
        hang = 1'b1;
        prog[0] = 16'h1005;
        prog[1] = 16'h1005;
        start_pulse(2);
        check("restart_halted_clear", Halted, 1'b0);
        check("restart_mem_addr", MemAddr, 0);
        wait_idle(40, el);
        hang = 1'b0;
        check("timeout_cycles", el, 10);
        check("timeout_error", Error, 1'b1);
        check("timeout_pc", PC, 0);
        check("timeout_count", InstrCount, 0);
        check("timeout_runs", run_log.size(), 1);
        tick();

        // Start pulses and a Length change while busy have no effect
        load_basic();
        start_pulse(3);
        check("restart_error_clear", Error, 1'b0);
        Length = ADDR_W'(1);
        for (int i = 0; i < 8; i++) begin
            Start = (i % 2 == 1);
            tick();
        end
        Start = 1'b0;
        wait_idle(40, el);
        check("busy_start_count", InstrCount, 3);
        check("busy_start_pc", PC, 2);
        check("busy_start_halted", Halted, 1'b1);

        // Length == 0: immediate halt, no run
        start_pulse(0);
        check("len0_halted", Halted, 1'b1);
        check("len0_busy", Busy, 1'b0);
        check("len0_count", InstrCount, 0);
        repeat (3) tick();
        check("len0_runs", run_log.size(), 0);

        // Stop in IDLE is ignored; Stop during the 2nd instruction's WAIT
        Stop = 1'b1; tick(); Stop = 1'b0; tick();
        prog[0] = 16'h1005;   // mv  r0,#5
        prog[1] = 16'h4001;   // add r0,r1
        prog[2] = 16'h1407;   // mv  r2,#7
        prog[3] = 16'h1601;   // mv  r3,#1
        prog[4] = 16'h4000;   // add r0,r0
        start_pulse(5);
        repeat (5) tick();
        Stop = 1'b1; tick(); Stop = 1'b0;
        wait_idle(40, el);
        check("stop_pc", PC, 1);
        check("stop_count", InstrCount, 2);
        check("stop_halted", Halted, 1'b0);
        check("stop_error", Error, 1'b0);
        check("stop_runs", run_log.size(), 2);

        // Stop coinciding with the final Done: completion wins
        load_basic();
        start_pulse(3);
        repeat (10) tick();
        Stop = 1'b1; tick(); Stop = 1'b0;
        check("stop_last_halted", Halted, 1'b1);
        check("stop_last_count", InstrCount, 3);
        check("stop_last_busy", Busy, 1'b0);

        // Reset during the add's WAIT, then a clean re-run
        start_pulse(3);
        repeat (8) tick();
        Resetn = 1'b0; tick(); Resetn = 1'b1;
        check("rst_busy", Busy, 1'b0);
        check("rst_run", Run, 1'b0);
        check("rst_pc", PC, 0);
        check("rst_count", InstrCount, 0);
        tick();
        start_pulse(3);
        wait_idle(40, el);
        check("rerun_count", InstrCount, 3);
        check("rerun_halted", Halted, 1'b1);
        check("rerun_cycle2", log_at(2), 8);
        check("rerun_r0", r[0], 16'h0105);
        check("rerun_r1", r[1], 16'h0100);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d checks so far", tests);
        $fatal(1);
    end

endmodule

// File: doc/proc_sequencer.md
Name: proc_sequencer

Overview:
- Program sequencer that feeds the 16-bit simple processor from a synchronous-read instruction memory.
- Fetches words from address 0 up to Length-1, presents each on the processor's DIN with a one-cycle Run pulse, and waits for Done before fetching the next word.
- Reports status to the system controller: Busy, Halted, Error (Done timeout) and a completed-instruction count.
- Sits between the instruction ROM/RAM and the processor; shares Clock and Resetn with both.

Parameters:
- ADDR_W, 5, width of the instruction memory address, PC and Length.
- TIMEOUT, 8, maximum number of WAIT cycles allowed without Done before Error is raised (must be at least 4).

Ports:
- Clock  input  1  system clock, rising edge.
- Resetn  input  1  synchronous, active-low reset.
- Start  input  1  single-cycle pulse; starts the program at address 0. Honoured only in IDLE.
- Stop  input  1  single-cycle pulse; requests a halt after the current instruction.
- Length  input  ADDR_W  number of instructions in the program; sampled on an accepted Start.
- MemAddr  output  ADDR_W  instruction memory read address, registered.
- MemData  input  16  instruction memory read data, valid one cycle after MemAddr.
- DIN  output  16  instruction word to the processor; combinational pass-through of MemData.
- Run  output  1  processor run strobe.
- Done  input  1  processor Done; combinational from the processor, high in its last time step.
- Busy  output  1  high in any state other than IDLE.
- Halted  output  1  sticky; program ran to completion.
- Error  output  1  sticky; Done timeout occurred.
- PC  output  ADDR_W  address of the current instruction.
- InstrCount  output  16  completed instructions since the last accepted Start; saturates at 16'hFFFF.

Behaviour:
- Reset, whenever Resetn=0 at a rising edge:
  - state is IDLE;
  - PC, MemAddr, InstrCount, the latched Length and the timeout counter are 0;
  - Run, Busy, Halted and Error are 0;
  - the stop-pending flag is cleared.
  - Reset mid-operation aborts at once: Run is 0 from the next cycle, and no instruction completes.
- States: IDLE, FETCH, ISSUE, WAIT.
- IDLE:
  - Run is 0.
  - On Start with Length != 0: latch Length; set PC and MemAddr to 0; clear Halted, Error, InstrCount and stop-pending; go to FETCH.
  - On Start with Length == 0: set Halted, clear Error and InstrCount, stay in IDLE.
- FETCH (1 cycle):
  - MemAddr equals PC and Run is 0.
  - Go to ISSUE.
- ISSUE (1 cycle):
  - Run is 1 and DIN equals MemData. The processor, which is in T0, captures IR at the end of this cycle.
  - Go to WAIT and clear the timeout counter.
- WAIT:
  - Run is 0 and the timeout counter increments each cycle.
  - Done=1: InstrCount increments (saturating), then exactly one of:
    - PC == Length-1: set Halted, go to IDLE;
    - otherwise, stop-pending set: clear it, go to IDLE with Halted=0;
    - otherwise: PC and MemAddr increment, go to FETCH.
  - Done=0 with the counter reaching TIMEOUT: set Error, go to IDLE. PC holds the failing address; InstrCount is not incremented.
- Throughput:
  - The first Run is asserted 2 cycles after the Start edge.
  - Each instruction costs 2 cycles (FETCH, ISSUE) plus the processor's execution cycles up to and including its Done cycle.
  - For a 1-step mv: FETCH, ISSUE, WAIT(Done), giving 3 cycles per instruction.
- Stop:
  - In FETCH, ISSUE or WAIT it sets stop-pending. The in-flight instruction always completes.
  - Stop in IDLE is ignored.
  - Stop coinciding with the final instruction's Done gives Halted=1 (completion has priority).
- Start while Busy is ignored.
- Run is never high for two consecutive cycles, and Run is never high while waiting for Done.
- PC never exceeds Length-1. There is no address wrap.
- Length changes after an accepted Start have no effect until the next Start.

Test Plan:
- Load the program mv r0,#5; mvt r1,#1; add r0,r1 (words 16'h1005, 16'h3201, 16'h4001), Length=3, Start pulse:
  - Run pulses are seen at cycles 2, 5, 8;
  - Halted=1 and InstrCount=3 after the add's Done;
  - processor r0=16'h0105, r1=16'h0100.
- Length=0, Start -> Halted=1 the next cycle, Busy stays 0, no Run pulse.
- 5-instruction program, Stop pulse during the second instruction's WAIT:
  - second instruction completes;
  - returns to IDLE with PC=1, InstrCount=2, Halted=0, Error=0.
- Done tied to 0, Length=2, TIMEOUT=8, Start:
  - a single Run pulse;
  - Error=1 after 8 WAIT cycles, IDLE, PC=0, InstrCount=0.
- Resetn=0 asserted during an add's WAIT:
  - next cycle Busy=0, Run=0, PC=0, InstrCount=0;
  - a subsequent Start re-runs from address 0 correctly.
- Start pulses issued while Busy:
  - no effect on PC or InstrCount;
  - Start after Halted clears Halted and Error and restarts at MemAddr=0.
